uart_msg_buffer: RTL and testbench

- Parametrised successor to the board's UART message buffer.
- Receive side: assembles bytes from the UART receiver into game messages and queues them in an RX FIFO for the game controller.
- Transmit side: queues controller messages in a TX FIFO and serialises each one into bytes for the UART transmitter.
- New over the previous generation: configurable message width and FIFO depth, inter-byte receive timeout/resync, sticky overflow flag, TX-full backpressure.

---
 rtl/uart_msg_buffer.sv | 206 ++++++++++++++++++++
 tb/tb_uart_msg_buffer.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_msg_buffer.sv
// uart_msg_buffer: frames UART bytes into game messages and back.
// RX bytes are assembled little-endian into messages and queued in a show-ahead FIFO;
// controller messages are queued in a TX FIFO and serialised one byte per txdone handshake.
module uart_msg_buffer #(
    parameter int unsigned ADDR_WIDTH     = 4,
    parameter int unsigned BUFFER_SIZE    = 4,
    parameter int unsigned PTR_WIDTH      = 2,
    parameter int unsigned TIMEOUT_CYCLES = 1000,
    localparam int unsigned MESSAGE_WIDTH = 2 * (ADDR_WIDTH + 1) + 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [7:0]               rxdata,
    input  logic                     rxfinish,
    output logic [7:0]               txdata,
    output logic                     send,
    input  logic                     txdone,
    output logic [MESSAGE_WIDTH-1:0] rxmessage,
    output logic                     rxvalid,
    input  logic                     ack_rxmessage,
    input  logic [MESSAGE_WIDTH-1:0] txmessage,
    input  logic                     txvalid,
    output logic                     ack_txmessage,
    output logic                     tx_full,
    output logic                     rx_overflow
);

    localparam int unsigned MW       = MESSAGE_WIDTH;
    localparam int unsigned NBYTES   = (MW + 7) / 8;
    localparam int unsigned SHW      = NBYTES * 8;
    localparam int unsigned IDX_W    = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam int unsigned CNT_W    = PTR_WIDTH + 1;
    localparam int unsigned TO_W     = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SEND = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;

    // ---------------- RX side ----------------
    logic [IDX_W-1:0]     rx_idx;
    logic [TO_W-1:0]      to_cnt;
    logic [SHW-1:0]       rx_buf;
    logic [SHW-1:0]       rx_word_c;
    logic                 rx_push_c;
    logic [MW-1:0]        rx_mem [BUFFER_SIZE];
    logic [PTR_WIDTH-1:0] rx_wr, rx_rd, rx_rd_n_c;
    logic [CNT_W-1:0]     rx_count, rx_count_n_c;
    logic                 rx_pop_c, rx_wr_c;
    logic [MW-1:0]        rx_head_n_c;

    // Current partial message with the incoming byte merged in at rx_idx
    always_comb begin
        rx_word_c = rx_buf;
        for (int k = 0; k < int'(NBYTES); k++) begin
            if (rx_idx == IDX_W'(k)) rx_word_c[8*k +: 8] = rxdata;
        end
    end

    assign rx_push_c = rxfinish && (rx_idx == LAST_IDX);

    // Byte assembler with inter-byte timeout that drops a stalled partial message
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_idx <= '0;
            to_cnt <= '0;
            rx_buf <= '0;
        end else if (rxfinish) begin
            rx_buf <= rx_word_c;
            rx_idx <= (rx_idx == LAST_IDX) ? '0 : rx_idx + IDX_W'(1);
            to_cnt <= '0;
        end else if (rx_idx != '0) begin
            if (to_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
                rx_idx <= '0;
                to_cnt <= '0;
            end else begin
                to_cnt <= to_cnt + TO_W'(1);
            end
        end
    end

    // RX FIFO next state; a push into a full FIFO only lands if the head is popped at the same edge
    always_comb begin
        rx_pop_c     = ack_rxmessage && (rx_count != '0);
        rx_wr_c      = rx_push_c && ((rx_count != CNT_W'(BUFFER_SIZE)) || rx_pop_c);
        rx_rd_n_c    = rx_rd + PTR_WIDTH'(rx_pop_c);
        rx_count_n_c = rx_count + CNT_W'(rx_wr_c) - CNT_W'(rx_pop_c);
        rx_head_n_c  = (rx_wr_c && (rx_wr == rx_rd_n_c)) ? rx_word_c[MW-1:0] : rx_mem[rx_rd_n_c];
    end

    // RX FIFO storage
    always_ff @(posedge clk) begin
        if (rx_wr_c) rx_mem[rx_wr] <= rx_word_c[MW-1:0];
    end

    // RX FIFO pointers, registered show-ahead head and sticky overflow
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_wr       <= '0;
            rx_rd       <= '0;
            rx_count    <= '0;
            rxvalid     <= 1'b0;
            rxmessage   <= '0;
            rx_overflow <= 1'b0;
        end else begin
            if (rx_wr_c) rx_wr <= rx_wr + PTR_WIDTH'(1);
            rx_rd     <= rx_rd_n_c;
            rx_count  <= rx_count_n_c;
            rxvalid   <= (rx_count_n_c != '0);
            rxmessage <= (rx_count_n_c != '0) ? rx_head_n_c : '0;
            if (rx_push_c && !rx_wr_c) rx_overflow <= 1'b1;
        end
    end

    // ---------------- TX side ----------------
    logic [MW-1:0]        tx_mem [BUFFER_SIZE];
    logic [PTR_WIDTH-1:0] tx_wr, tx_rd;
    logic [CNT_W-1:0]     tx_count, tx_count_n_c;
    logic                 tx_acc_c, tx_pop_c;
    logic [1:0]           state, state_n;
    logic [IDX_W-1:0]     tx_idx, tx_idx_n;
    logic [SHW-1:0]       tx_shift;

    assign tx_acc_c     = txvalid && !tx_full && !ack_txmessage;
    assign tx_count_n_c = tx_count + CNT_W'(tx_acc_c) - CNT_W'(tx_pop_c);

    // TX FIFO storage
    always_ff @(posedge clk) begin
        if (tx_acc_c) tx_mem[tx_wr] <= txmessage;
    end

    // TX FIFO pointers, accept handshake and full flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_wr         <= '0;
            tx_rd         <= '0;
            tx_count      <= '0;
            ack_txmessage <= 1'b0;
            tx_full       <= 1'b0;
        end else begin
            if (tx_acc_c) tx_wr <= tx_wr + PTR_WIDTH'(1);
            if (tx_pop_c) tx_rd <= tx_rd + PTR_WIDTH'(1);
            tx_count      <= tx_count_n_c;
            ack_txmessage <= tx_acc_c;
            tx_full       <= (tx_count_n_c == CNT_W'(BUFFER_SIZE));
        end
    end

    // Serialiser state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            tx_idx <= '0;
        end else begin
            state  <= state_n;
            tx_idx <= tx_idx_n;
        end
    end

    // Serialiser next state: pop in IDLE, one send pulse per byte, advance on txdone
    always_comb begin
        state_n  = state;
        tx_idx_n = tx_idx;
        tx_pop_c = 1'b0;
        case (state)
            S_IDLE: begin
                if (tx_count != '0) begin
                    tx_pop_c = 1'b1;
                    tx_idx_n = '0;
                    state_n  = S_SEND;
                end
            end
            S_SEND: state_n = S_WAIT;
            S_WAIT: begin
                if (txdone) begin
                    if (tx_idx == LAST_IDX) begin
                        state_n = S_IDLE;
                    end else begin
                        tx_idx_n = tx_idx + IDX_W'(1);
                        state_n  = S_SEND;
                    end
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    // Registered byte output; upper pad bits of the last byte come out as zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            txdata   <= '0;
            send     <= 1'b0;
            tx_shift <= '0;
        end else begin
            send <= (state_n == S_SEND);
            if (tx_pop_c) begin
                txdata   <= tx_mem[tx_rd][7:0];
                tx_shift <= SHW'(tx_mem[tx_rd]) >> 8;
            end else if ((state == S_WAIT) && (state_n == S_SEND)) begin
                txdata   <= tx_shift[7:0];
                tx_shift <= tx_shift >> 8;
            end
        end
    end

endmodule

// File: tb/tb_uart_msg_buffer.sv
// Self-checking bench for uart_msg_buffer (defaults, short RX timeout of 10 cycles).
module tb_uart_msg_buffer;

    logic        clk;
    logic        rst_n;
    logic [7:0]  rxdata;
    logic        rxfinish;
    logic [7:0]  txdata;
    logic        send;
    logic        txdone;
    logic [13:0] rxmessage;
    logic        rxvalid;
    logic        ack_rx;
    logic [13:0] txmessage;
    logic        txvalid;
    logic        ack_tx;
    logic        tx_full;
    logic        rx_overflow;

    uart_msg_buffer #(
        .ADDR_WIDTH(4), .BUFFER_SIZE(4), .PTR_WIDTH(2), .TIMEOUT_CYCLES(10)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .rxdata(rxdata), .rxfinish(rxfinish),
        .txdata(txdata), .send(send), .txdone(txdone),
        .rxmessage(rxmessage), .rxvalid(rxvalid), .ack_rxmessage(ack_rx),
        .txmessage(txmessage), .txvalid(txvalid), .ack_txmessage(ack_tx),
        .tx_full(tx_full), .rx_overflow(rx_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int n_sends = 0;
    logic auto_done;

    logic [13:0] rx_q[$];
    logic [7:0]  tx_q[$];

    typedef struct {
        logic [7:0]  b0;
        logic [7:0]  b1;
        logic [13:0] msg;
    } rx_vec_t;
    rx_vec_t rx_vecs [4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rx_byte(input logic [7:0] b);
        rxdata   = b;
        rxfinish = 1'b1;
        tick();
        rxfinish = 1'b0;
    endtask

    task automatic rx_msg(input logic [7:0] b0, input logic [7:0] b1);
        rx_byte(b0);
        rx_byte(b1);
    endtask

    task automatic rx_pop_check(input string name);
        logic [13:0] exp;
        check({name, "_valid"}, 32'(rxvalid), 32'd1);
        check({name, "_sb"}, 32'(rx_q.size() != 0), 32'd1);
        if (rx_q.size() != 0) begin
            exp = rx_q.pop_front();
            check(name, 32'(rxmessage), 32'(exp));
        end
        ack_rx = 1'b1;
        tick();
        ack_rx = 1'b0;
    endtask

    task automatic push_tx(input logic [13:0] m);
        tx_q.push_back(m[7:0]);
        tx_q.push_back({2'b00, m[13:8]});
    endtask

    task automatic drain_tx(input int budget);
        for (int c = 0; c < budget && tx_q.size() != 0; c++) tick();
        check("tx_drain", 32'(tx_q.size()), 32'd0);
    endtask

    // Scoreboard: every send pulse must match the next expected byte
    always @(negedge clk) begin
        if (send) begin
            n_sends++;
            check("tx_send_expected", 32'(tx_q.size() != 0), 32'd1);
            if (tx_q.size() != 0) check("tx_byte", 32'(txdata), 32'(tx_q.pop_front()));
        end
    end

    // Transmitter model: answers each send with txdone two cycles later when enabled
    initial begin : txdone_responder
        logic pending;
        pending = 1'b0;
        txdone  = 1'b0;
        forever begin
            @(negedge clk);
            if (send) pending = 1'b1;
            if (auto_done && pending) begin
                pending = 1'b0;
                @(posedge clk); #1;
                @(posedge clk); #1;
                txdone = 1'b1;
                @(posedge clk); #1;
                txdone = 1'b0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d", n_tests);
        $fatal(1);
    end

    initial begin
        int base;
        int acks;
        bit got;
        logic [13:0] msg;

        rx_vecs[0] = '{8'h5A, 8'hEC, 14'h2C5A};
        rx_vecs[1] = '{8'hA5, 8'hC3, 14'h03A5};
        rx_vecs[2] = '{8'h34, 8'hD2, 14'h1234};
        rx_vecs[3] = '{8'hFF, 8'hFF, 14'h3FFF};

        rst_n = 1'b0; rxdata = '0; rxfinish = 1'b0; ack_rx = 1'b0;
        txmessage = '0; txvalid = 1'b0; auto_done = 1'b1;

        // Reset values
        repeat (2) tick();
        check("rst_txdata", 32'(txdata), 32'd0);
        check("rst_send", 32'(send), 32'd0);
        check("rst_ack_tx", 32'(ack_tx), 32'd0);
        check("rst_rxvalid", 32'(rxvalid), 32'd0);
        check("rst_tx_full", 32'(tx_full), 32'd0);
        check("rst_rx_overflow", 32'(rx_overflow), 32'd0);
        rst_n = 1'b1;
        tick();

        // RX assembly from the vector table
        for (int i = 0; i < 4; i++) begin
            rx_byte(rx_vecs[i].b0);
            check("rx_partial_not_valid", 32'(rxvalid), 32'd0);
            rx_byte(rx_vecs[i].b1);
            rx_q.push_back(rx_vecs[i].msg);
            rx_pop_check("rx_vec_msg");
            check("rx_vec_empty_after_ack", 32'(rxvalid), 32'd0);
        end

        // TX basic: ack for one cycle, bytes little-endian, then quiet
        base = n_sends;
        txmessage = 14'h1234;
        txvalid   = 1'b1;
        tick();
        txvalid = 1'b0;
        push_tx(14'h1234);
        check("tx_ack_pulse", 32'(ack_tx), 32'd1);
        tick();
        check("tx_ack_single", 32'(ack_tx), 32'd0);
        check("tx_first_send_latency", 32'(send), 32'd1);
        check("tx_first_byte", 32'(txdata), 32'h34);
        drain_tx(100);
        repeat (10) tick();
        check("tx_basic_send_count", 32'(n_sends - base), 32'd2);
        check("tx_basic_not_full", 32'(tx_full), 32'd0);

        // RX overflow: fifth message dropped, first four intact
        for (int i = 1; i <= 5; i++) begin
            rx_msg(8'(i), 8'h00);
            if (i <= 4) rx_q.push_back(14'(i));
            if (i == 4) check("rx_no_overflow_at_full", 32'(rx_overflow), 32'd0);
        end
        check("rx_overflow_set", 32'(rx_overflow), 32'd1);
        check("rx_overflow_head", 32'(rxmessage), 32'd1);
        for (int i = 0; i < 4; i++) rx_pop_check("rx_overflow_pop");
        check("rx_overflow_drained", 32'(rxvalid), 32'd0);
        check("rx_overflow_sticky", 32'(rx_overflow), 32'd1);

        // RX timeout discards a stale partial byte; a short gap does not
        rx_byte(8'hFF);
        repeat (12) tick();
        rx_msg(8'h01, 8'h02);
        rx_q.push_back(14'h0201);
        rx_pop_check("rx_after_timeout");
        rx_byte(8'h11);
        repeat (5) tick();
        rx_byte(8'h22);
        rx_q.push_back(14'h2211);
        rx_pop_check("rx_short_gap");

        // TX backpressure with txdone withheld
        auto_done = 1'b0;
        base = n_sends;
        acks = 0;
        for (int k = 0; k < 6; k++) begin
            msg = 14'(16'h0101 + 16'(k) * 16'h0213);
            txmessage = msg;
            txvalid   = 1'b1;
            got = 1'b0;
            for (int c = 0; c < 8 && !got; c++) begin
                tick();
                if (ack_tx) got = 1'b1;
            end
            if (got) begin
                acks++;
                push_tx(msg);
            end
        end
        check("tx_bp_acks", 32'(acks), 32'd5);
        check("tx_bp_full", 32'(tx_full), 32'd1);
        auto_done = 1'b1;
        got = 1'b0;
        for (int c = 0; c < 60 && !got; c++) begin
            tick();
            if (ack_tx) got = 1'b1;
        end
        check("tx_bp_sixth_acked", 32'(got), 32'd1);
        check("tx_bp_ack_after_msg_done", 32'((n_sends - base) >= 2), 32'd1);
        if (got) push_tx(txmessage);
        txvalid = 1'b0;
        drain_tx(400);
        repeat (10) tick();
        check("tx_bp_send_count", 32'(n_sends - base), 32'd12);
        check("tx_bp_not_full", 32'(tx_full), 32'd0);

        // Reset mid TX-WAIT and mid RX message
        auto_done = 1'b0;
        txmessage = 14'h2ABC;
        txvalid   = 1'b1;
        tick();
        txvalid = 1'b0;
        check("rst_seq_ack", 32'(ack_tx), 32'd1);
        tx_q.push_back(8'hBC);
        repeat (3) tick();
        rx_byte(8'h77);
        base = n_sends;
        rst_n = 1'b0;
        #1;
        check("rst_async_txdata", 32'(txdata), 32'd0);
        check("rst_async_send", 32'(send), 32'd0);
        check("rst_async_ack_tx", 32'(ack_tx), 32'd0);
        check("rst_async_rxvalid", 32'(rxvalid), 32'd0);
        check("rst_async_tx_full", 32'(tx_full), 32'd0);
        check("rst_async_rx_overflow", 32'(rx_overflow), 32'd0);
        tick();
        rst_n = 1'b1;
        auto_done = 1'b1;
        tick();
        rx_msg(8'h99, 8'h03);
        rx_q.push_back(14'h0399);
        rx_pop_check("rst_fresh_rx");
        repeat (10) tick();
        check("rst_no_stale_send", 32'(n_sends - base), 32'd0);

        // Push into a full RX FIFO while the head is popped at the same edge
        for (int i = 0; i < 4; i++) begin
            rx_msg(8'(8'h10 + i), 8'h00);
            rx_q.push_back(14'(16'h0010 + i));
        end
        rx_byte(8'h14);
        rxdata   = 8'h00;
        rxfinish = 1'b1;
        ack_rx   = 1'b1;
        tick();
        rxfinish = 1'b0;
        ack_rx   = 1'b0;
        void'(rx_q.pop_front());
        rx_q.push_back(14'h0014);
        check("rx_full_pop_push_no_overflow", 32'(rx_overflow), 32'd0);
        for (int i = 0; i < 4; i++) rx_pop_check("rx_full_pop_push");
        check("rx_full_pop_push_drained", 32'(rxvalid), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
